// File: rtl/down_timer_pkg.sv
// Shared types, widths and a saturating decrement for the down_timer block.
// The timer's state encoding lives here so the top and any wrapper agree on it.
package down_timer_pkg;

  localparam int COUNT_W = 8;
  localparam int PRESC_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Decrement that sticks at zero instead of wrapping.
  function automatic logic [COUNT_W-1:0] dec_sat(input logic [COUNT_W-1:0] v);
    if (v == '0) begin
      return '0;
    end
    return v - COUNT_W'(1);
  endfunction

endpackage

// File: rtl/down_timer_prescale.sv
// Tick divider: one tick every presc+1 enabled clocks, restartable via clr.
// The counter freezes while en is low so a paused timer keeps its phase.
module down_timer_prescale
  import down_timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] r_cnt;
  logic [PRESC_W-1:0] w_cnt_next;
  logic               w_match;

  // >= rather than == so lowering presc mid-count fires at the next compare
  // instead of running the counter all the way round.
  assign w_match = (r_cnt >= presc);
  assign tick    = en && !clr && w_match;

  always_comb begin
    w_cnt_next = r_cnt;
    if (clr) begin
      w_cnt_next = '0;
    end else if (en) begin
      if (w_match) begin
        w_cnt_next = '0;
      end else begin
        w_cnt_next = r_cnt + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

endmodule

// File: rtl/down_timer.sv
// Programmable 8-bit down timer with pause, auto-reload, done pulse and sticky irq.
// All outputs come straight from registers; the prescaler paces decrements.
module down_timer
  import down_timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_val,
  input  logic               start,
  input  logic               stop,
  input  logic               auto_reload,
  input  logic [PRESC_W-1:0] presc,
  input  logic               irq_clr,
  output logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               done,
  output logic               irq
);

  state_t             r_state;
  state_t             w_state_next;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] w_count_next;
  logic [COUNT_W-1:0] r_reload;
  logic [COUNT_W-1:0] w_reload_next;
  logic               r_busy;
  logic               r_done;
  logic               w_done_next;
  logic               r_irq;
  logic               w_irq_next;

  logic [COUNT_W-1:0] w_eff_count;
  logic               w_enter_run;
  logic               w_presc_en;
  logic               w_presc_clr;
  logic               w_tick;

  // Count as it will stand after this cycle's load, used for the start check.
  assign w_eff_count = load ? load_val : r_count;
  assign w_enter_run = start && !stop && (r_state != ST_RUN) && (w_eff_count != '0);
  assign w_presc_en  = (r_state == ST_RUN) && !stop;
  assign w_presc_clr = load || w_enter_run;

  down_timer_prescale u_prescale (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_presc_clr),
    .en    (w_presc_en),
    .presc (presc),
    .tick  (w_tick)
  );

  always_comb begin
    w_state_next  = r_state;
    w_count_next  = w_eff_count;
    w_reload_next = load ? load_val : r_reload;
    w_done_next   = 1'b0;
    w_irq_next    = r_irq && !irq_clr;

    case (r_state)
      ST_IDLE: begin
        if (w_enter_run) begin
          w_state_next = ST_RUN;
        end
      end

      ST_PAUSE: begin
        if (stop) begin
          w_state_next = ST_IDLE;
        end else if (w_enter_run) begin
          w_state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        // w_tick is already masked on load cycles, so load always wins.
        if (stop) begin
          w_state_next = ST_PAUSE;
        end else if (w_tick) begin
          if (r_count == COUNT_W'(1)) begin
            w_done_next = 1'b1;
            w_irq_next  = 1'b1;
            if (auto_reload && (r_reload != '0)) begin
              w_count_next = r_reload;
            end else begin
              w_count_next = '0;
              w_state_next = ST_IDLE;
            end
          end else if (r_count == '0) begin
            w_state_next = ST_IDLE;
          end else begin
            w_count_next = dec_sat(r_count);
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_reload <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_count  <= w_count_next;
      r_reload <= w_reload_next;
      r_busy   <= (w_state_next == ST_RUN);
      r_done   <= w_done_next;
      r_irq    <= w_irq_next;
    end
  end

  assign count = r_count;
  assign busy  = r_busy;
  assign done  = r_done;
  assign irq   = r_irq;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: hand-computed counts, pulses and flags per cycle.
module tb_down_timer;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] load_val;
  logic       start;
  logic       stop;
  logic       auto_reload;
  logic [3:0] presc;
  logic       irq_clr;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       irq;

  int n_checks = 0;
  int n_fail   = 0;

  down_timer dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .presc       (presc),
    .irq_clr     (irq_clr),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    if (obs === exp) $display("ok %s value=%0d", tag, obs);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
    if (obs === exp) $display("ok %s value=%0b", tag, obs);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_val = 8'd0; start = 1'b0; stop = 1'b0;
    auto_reload = 1'b0; presc = 4'd0; irq_clr = 1'b0;

    // Reset state
    repeat (2) cyc();
    chk8("rst_count", count, 8'd0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_irq", irq, 1'b0);
    rst = 1'b0;
    cyc();

    // Load 5, presc 0: 4,3,2,1,0 on consecutive edges
    load = 1'b1; load_val = 8'd5; cyc(); load = 1'b0;
    chk8("a_loaded", count, 8'd5);
    chk1("a_idle_busy", busy, 1'b0);
    start = 1'b1; cyc(); start = 1'b0;
    chk1("a_busy_start", busy, 1'b1);
    chk8("a_count_start", count, 8'd5);
    for (int k = 4; k >= 1; k--) begin
      cyc();
      chk8($sformatf("a_count_%0d", k), count, 8'(k));
      chk1($sformatf("a_done_%0d", k), done, 1'b0);
    end
    cyc();
    chk8("a_count_0", count, 8'd0);
    chk1("a_done_pulse", done, 1'b1);
    chk1("a_irq_set", irq, 1'b1);
    chk1("a_busy_fall", busy, 1'b0);
    cyc();
    chk1("a_done_once", done, 1'b0);
    chk1("a_irq_sticky", irq, 1'b1);
    irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
    chk1("a_irq_clr", irq, 1'b0);

    // Load 3, presc 3: decrement every 4 cycles, done 12 cycles after start
    presc = 4'd3;
    load = 1'b1; load_val = 8'd3; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      cyc();
      chk8($sformatf("b_count_c%0d", n), count, 8'(3 - n / 4));
      chk1($sformatf("b_done_c%0d", n), done, n == 12);
    end
    chk1("b_busy_end", busy, 1'b0);
    cyc();
    chk1("b_done_after", done, 1'b0);
    irq_clr = 1'b1; cyc(); irq_clr = 1'b0;

    // Auto-reload 2, presc 0: 1,2,1,2 with a done each period
    presc = 4'd0; auto_reload = 1'b1;
    load = 1'b1; load_val = 8'd2; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      cyc();
      chk8($sformatf("c_count_c%0d", n), count, (n % 2 == 1) ? 8'd1 : 8'd2);
      chk1($sformatf("c_done_c%0d", n), done, n % 2 == 0);
      chk1($sformatf("c_busy_c%0d", n), busy, 1'b1);
    end
    stop = 1'b1; cyc();
    chk8("c_pause_count", count, 8'd2);
    chk1("c_pause_busy", busy, 1'b0);
    cyc(); stop = 1'b0;
    auto_reload = 1'b0;
    irq_clr = 1'b1; cyc(); irq_clr = 1'b0;

    // Pause at 7, resume to 6, stop twice to idle
    load = 1'b1; load_val = 8'd7; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    chk8("d_run_7", count, 8'd7);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk8("d_pause_7", count, 8'd7);
    chk1("d_pause_busy", busy, 1'b0);
    cyc();
    chk8("d_pause_hold", count, 8'd7);
    start = 1'b1; cyc(); start = 1'b0;
    chk1("d_resume_busy", busy, 1'b1);
    cyc();
    chk8("d_resume_6", count, 8'd6);
    stop = 1'b1; cyc();
    chk8("d_stop1_count", count, 8'd6);
    cyc(); stop = 1'b0;
    cyc();
    chk8("d_idle_count", count, 8'd6);
    chk1("d_idle_busy", busy, 1'b0);

    // Start with count 0 is ignored; start+stop from idle stays idle
    load = 1'b1; load_val = 8'd0; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    chk1("e_zero_busy", busy, 1'b0);
    chk1("e_zero_done", done, 1'b0);
    cyc();
    chk1("e_zero_done2", done, 1'b0);
    load = 1'b1; load_val = 8'd4; cyc(); load = 1'b0;
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    chk1("e_ss_busy", busy, 1'b0);
    cyc();
    chk8("e_ss_count", count, 8'd4);
    chk1("e_ss_busy2", busy, 1'b0);

    // Load together with start uses the new value
    load = 1'b1; start = 1'b1; load_val = 8'd2; cyc(); load = 1'b0; start = 1'b0;
    chk1("f_ls_busy", busy, 1'b1);
    chk8("f_ls_count", count, 8'd2);
    cyc();
    chk8("f_ls_count1", count, 8'd1);
    cyc();
    chk1("f_ls_done", done, 1'b1);
    irq_clr = 1'b1; cyc(); irq_clr = 1'b0;

    // Load during run wins over the tick
    load = 1'b1; load_val = 8'd9; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    chk8("g_run_8", count, 8'd8);
    load = 1'b1; load_val = 8'd5; cyc(); load = 1'b0;
    chk8("g_load_5", count, 8'd5);
    chk1("g_load_busy", busy, 1'b1);
    cyc();
    chk8("g_dec_4", count, 8'd4);

    // Asynchronous reset mid-run clears outputs before the next edge
    #2 rst = 1'b1;
    #1;
    chk8("h_async_count", count, 8'd0);
    chk1("h_async_busy", busy, 1'b0);
    cyc(); rst = 1'b0;
    cyc();
    chk8("h_after_count", count, 8'd0);
    chk1("h_after_busy", busy, 1'b0);

    // irq_clr coinciding with expiry leaves irq set
    load = 1'b1; load_val = 8'd1; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    chk1("i_irq_pre", irq, 1'b0);
    irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
    chk1("i_done", done, 1'b1);
    chk1("i_irq_wins", irq, 1'b1);
    irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
    chk1("i_irq_cleared", irq, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port load, input, 1 bit: when high, copies load_val into count and the reload register.
REQ-004 SHALL have port load_val, input, 8 bits: value used by load.
REQ-005 SHALL have port start, input, 1 bit: request to enter RUN.
REQ-006 SHALL have port stop, input, 1 bit: request to pause or halt.
REQ-007 SHALL have port auto_reload, input, 1 bit: when high, the timer restarts from the reload register on expiry.
REQ-008 SHALL have port presc, input, 4 bits: tick divider; one decrement per presc+1 clocks.
REQ-009 SHALL have port irq_clr, input, 1 bit: clears irq.
REQ-010 SHALL have port count, output, 8 bits: current count value, registered.
REQ-011 SHALL have port busy, output, 1 bit: high while in state RUN.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse on expiry.
REQ-013 SHALL have port irq, output, 1 bit: sticky expiry flag.

Function
REQ-014 SHALL implement the states IDLE, RUN and PAUSE.
REQ-015 SHALL, on load in any state, set count and reload to load_val, clear the prescaler, and leave the state unchanged.
REQ-016 SHALL move from IDLE or PAUSE to RUN on start when the post-load count is nonzero; start with count==0 SHALL be ignored and SHALL NOT assert done.
REQ-017 SHALL move from RUN to PAUSE on stop, hold count, and freeze the prescaler; stop in PAUSE SHALL move to IDLE; stop in IDLE SHALL have no effect.
REQ-018 SHALL give stop priority over start when both are asserted in the same cycle.
REQ-019 SHALL clear the prescaler on entry to RUN and SHALL assert tick when the prescaler equals presc; on tick the prescaler SHALL return to 0.
REQ-020 SHALL decrement count by 1 on each tick in RUN; count SHALL never wrap below 0.
REQ-021 SHALL treat a tick with count==1 as expiry: done=1 for exactly the following cycle and irq set.
REQ-022 SHALL, at expiry with auto_reload=1 and reload!=0, load count from reload and stay in RUN; otherwise count SHALL become 0 and the state SHALL go to IDLE.
REQ-023 SHALL give decrement latency from start: the first decrement occurs presc+1 cycles after the start edge (presc=0 means every cycle).
REQ-024 SHALL give irq set priority over irq_clr when both occur in the same cycle.
REQ-025 SHALL apply load before any decrement when load and tick coincide, and SHALL NOT decrement in that cycle.
REQ-026 SHALL sample presc continuously; a change takes effect at the next prescaler compare.

Reset
REQ-027 SHALL, while rst is high, force state=IDLE, count=0, reload=0, prescaler=0, busy=0, done=0 and irq=0, regardless of clk.
REQ-028 SHALL discard any run in progress when rst is asserted mid-operation, and SHALL resume only on a new load or start after release.

Structure
REQ-029 SHALL place the state enum, COUNT_W=8 and PRESC_W=4 in the shared package down_timer_pkg.
REQ-030 SHALL implement the prescaler as the sub-module down_timer_prescale, with ports clk, rst, clr, en, presc and tick.
REQ-031 SHALL register all outputs and SHALL contain no combinational path from inputs to outputs.

Verification
REQ-032 SHALL cover this scenario: load 5, presc=0, start -> count 4,3,2,1,0 on consecutive edges; done pulses once; irq=1; busy falls with done.
REQ-033 SHALL cover this scenario: load 3, presc=3, start -> count decrements every 4 cycles; done 12 cycles after start.
REQ-034 SHALL cover this scenario: load 2, auto_reload=1, presc=0 -> count 1,2,1,2...; a done pulse each period; busy stays 1.
REQ-035 SHALL cover this scenario: RUN at count 7, stop -> PAUSE with count held at 7; start -> resumes 6; stop, stop -> IDLE.
REQ-036 SHALL cover this scenario: start with count 0 -> remains IDLE with no done; start+stop together from IDLE -> remains IDLE.
REQ-037 SHALL cover this scenario: rst asserted mid-RUN between edges -> outputs zero immediately; irq_clr coinciding with expiry -> irq remains 1.
